// File: rtl/mem_bus_controller_pkg.sv
// mem_bus_controller_pkg: address map, IO offsets, FSM/region encodings and decode helper.
// Revision 1.0
`default_nettype none

package mem_bus_controller_pkg;

   localparam logic [15:0] ROM_LIMIT = 16'h00FF;
   localparam logic [15:0] RAM_LIMIT = 16'hFEFF;
   localparam logic [15:0] IO_LIMIT  = 16'hFF03;

   localparam logic [1:0] IO_GPIO_OUT = 2'd0;
   localparam logic [1:0] IO_GPIO_IN  = 2'd1;
   localparam logic [1:0] IO_STATUS   = 2'd2;
   localparam logic [1:0] IO_HALT     = 2'd3;

   localparam int WAIT_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      RG_ROM  = 2'd0,
      RG_RAM  = 2'd1,
      RG_IO   = 2'd2,
      RG_NONE = 2'd3
   } region_t;

   // Regions are contiguous from 0x0000, so ordered upper-limit compares suffice.
   function automatic region_t decode_region(input logic [15:0] addr);
      if (addr <= ROM_LIMIT)      return RG_ROM;
      else if (addr <= RAM_LIMIT) return RG_RAM;
      else if (addr <= IO_LIMIT)  return RG_IO;
      else                        return RG_NONE;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mem_bus_controller_if.sv
// mem_bus_controller_if: CPU-side memory bus between cpu_top and the bus controller.
// Revision 1.0
`default_nettype none

interface mem_bus_controller_if;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_rd;
   logic        cpu_wr;
   logic [7:0]  cpu_rdata;
   logic        cpu_rd_oe;
   logic        cpu_ready;

   modport master (
      output cpu_addr, cpu_wdata, cpu_rd, cpu_wr,
      input  cpu_rdata, cpu_rd_oe, cpu_ready
   );

   modport slave (
      input  cpu_addr, cpu_wdata, cpu_rd, cpu_wr,
      output cpu_rdata, cpu_rd_oe, cpu_ready
   );
endinterface

`default_nettype wire

// File: rtl/mem_bus_controller_sync_2ff.sv
// sync_2ff: two-flop synchroniser for asynchronous inputs, clears to zero on reset.
// Revision 1.0
`default_nettype none

module sync_2ff #(
   parameter int WIDTH = 8
) (
   input  wire logic             clk,
   input  wire logic             reset,
   input  wire logic [WIDTH-1:0] d,
   output logic      [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

`default_nettype wire

// File: rtl/mem_bus_controller.sv
// mem_bus_controller: decodes CPU accesses to ROM/RAM/IO with per-region wait states,
// hosts GPIO/status/halt registers and a sticky bus-error flag.  Revision 1.0
`default_nettype none

module mem_bus_controller
   import mem_bus_controller_pkg::*;
#(
   parameter int ROM_WAIT = 1,
   parameter int RAM_WAIT = 0,
   parameter int RAM_AW   = 12
) (
   input  wire logic              clk,
   input  wire logic              reset,
   mem_bus_controller_if.slave    cpu,
   output logic [7:0]             rom_addr,
   input  wire logic [7:0]        rom_data,
   output logic [RAM_AW-1:0]      ram_addr,
   output logic [7:0]             ram_wdata,
   output logic                   ram_we,
   input  wire logic [7:0]        ram_rdata,
   input  wire logic [7:0]        gpio_in,
   output logic [7:0]             gpio_out,
   output logic                   halt,
   output logic                   bus_err
);

   state_t              state_q, state_d;
   region_t             region_q, acc_region;
   logic [RAM_AW-1:0]   addr_q;
   logic [7:0]          wdata_q, gpio_out_q, gpio_sync, io_rdata, mem_rdata;
   logic [WAIT_W-1:0]   cnt_q, acc_wait;
   logic                rd_q, err_q, first_q, halt_q, bus_err_q;
   logic                accept, acc_err, io_wr, status_clr, ready;

   sync_2ff #(.WIDTH(8)) u_gpio_sync (
      .clk   (clk),
      .reset (reset),
      .d     (gpio_in),
      .q     (gpio_sync)
   );

   always_comb begin
      acc_region = decode_region(cpu.cpu_addr);
      acc_err    = (acc_region == RG_NONE) || (cpu.cpu_rd && cpu.cpu_wr) ||
                   (acc_region == RG_ROM && cpu.cpu_wr);
      case (acc_region)
         RG_ROM:  acc_wait = WAIT_W'(ROM_WAIT);
         RG_RAM:  acc_wait = WAIT_W'(RAM_WAIT);
         default: acc_wait = '0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cpu.cpu_rd || cpu.cpu_wr) begin
               accept  = 1'b1;
               state_d = ST_ACCESS;
            end
         end
         ST_ACCESS: if (cnt_q == '0) state_d = ST_RESP;
         ST_RESP:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Request is captured once at accept; later CPU bus changes cannot disturb the access.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_q   <= '0;
         wdata_q  <= '0;
         rd_q     <= 1'b0;
         err_q    <= 1'b0;
         region_q <= RG_ROM;
         cnt_q    <= '0;
         first_q  <= 1'b0;
      end else if (accept) begin
         addr_q   <= cpu.cpu_addr[RAM_AW-1:0];
         wdata_q  <= cpu.cpu_wdata;
         rd_q     <= cpu.cpu_rd && !cpu.cpu_wr;
         err_q    <= acc_err;
         region_q <= acc_region;
         cnt_q    <= acc_wait;
         first_q  <= 1'b1;
      end else if (state_q == ST_ACCESS) begin
         first_q <= 1'b0;
         if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
      end
   end

   assign io_wr      = (state_q == ST_RESP) && !rd_q && !err_q && (region_q == RG_IO);
   assign status_clr = io_wr && (addr_q[1:0] == IO_STATUS) && wdata_q[0];

   // A new error and a STATUS clear in the same cycle resolve with the set winning.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gpio_out_q <= '0;
         halt_q     <= 1'b0;
         bus_err_q  <= 1'b0;
      end else begin
         if (io_wr && addr_q[1:0] == IO_GPIO_OUT) gpio_out_q <= wdata_q;
         if (io_wr && addr_q[1:0] == IO_HALT)     halt_q     <= 1'b1;
         if (accept && acc_err)                   bus_err_q  <= 1'b1;
         else if (status_clr)                     bus_err_q  <= 1'b0;
      end
   end

   always_comb begin
      case (addr_q[1:0])
         IO_GPIO_OUT: io_rdata = gpio_out_q;
         IO_GPIO_IN:  io_rdata = gpio_sync;
         IO_STATUS:   io_rdata = {6'b0, halt_q, bus_err_q};
         default:     io_rdata = {7'b0, halt_q};
      endcase
      case (region_q)
         RG_ROM:  mem_rdata = rom_data;
         RG_RAM:  mem_rdata = ram_rdata;
         RG_IO:   mem_rdata = io_rdata;
         default: mem_rdata = 8'h00;
      endcase
   end

   assign ready         = (state_q == ST_RESP);
   assign cpu.cpu_ready = ready;
   assign cpu.cpu_rd_oe = ready && rd_q;
   assign cpu.cpu_rdata = (ready && rd_q && !err_q) ? mem_rdata : 8'h00;

   assign ram_we    = (state_q == ST_ACCESS) && first_q && !rd_q && !err_q && (region_q == RG_RAM);
   assign rom_addr  = addr_q[7:0];
   assign ram_addr  = addr_q;
   assign ram_wdata = wdata_q;
   assign gpio_out  = gpio_out_q;
   assign halt      = halt_q;
   assign bus_err   = bus_err_q;

endmodule

`default_nettype wire
